// File: rtl/hyperbus_cfg_shadow_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_cfg_shadow_regs_if
// Purpose  : Register-bus request/response bundle for the HyperBus config block.
// Revision : 1.0 - initial release
// ============================================================================
interface hyperbus_cfg_shadow_regs_if;
  logic        valid;
  logic        ready;
  logic        write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rvalid;
  logic [31:0] rdata;
  logic        error;

  modport master (
    output valid, write, addr, wdata, wstrb,
    input  ready, rvalid, rdata, error
  );

  modport slave (
    input  valid, write, addr, wdata, wstrb,
    output ready, rvalid, rdata, error
  );
endinterface
`default_nettype wire

// File: rtl/hyperbus_cfg_shadow_regs.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_cfg_shadow_regs
// Purpose  : HyperBus timing/address-map registers, shadow written by software,
//            copied atomically to active set when the PHY is idle.
//            Optional map validation at commit: HYPERBUS_CFG_MAP_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hyperbus_cfg_shadow_regs #(
  parameter int unsigned NR_CS       = 2,
  parameter logic [31:0] CS_SIZE     = 32'h0040_0000,
  parameter int unsigned LAT_W       = 4,
  parameter int unsigned CSMAX_W     = 16,
  parameter int unsigned DLY_W       = 4,
  parameter int unsigned RST_LAT_ACC = 6,
  parameter int unsigned RST_LAT_ADD = 6,
  parameter int unsigned RST_CSMAX   = 665,
  parameter int unsigned RST_RWR     = 6,
  parameter int unsigned RST_DLY     = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  hyperbus_cfg_shadow_regs_if.slave cfg,
  input  logic                      phy_idle_i,
  output logic [LAT_W-1:0]          t_lat_acc_o,
  output logic [LAT_W-1:0]          t_lat_add_o,
  output logic [LAT_W-1:0]          t_rwr_o,
  output logic [CSMAX_W-1:0]        t_cs_max_o,
  output logic [DLY_W-1:0]          t_dly_o,
  output logic [64*NR_CS-1:0]       addr_map_o,
  output logic                      cfg_update_o,
  output logic                      commit_pending_o
);

  localparam int unsigned c_cs_w = (NR_CS > 1) ? $clog2(NR_CS) : 1;

  localparam logic [5:0] c_idx_ctrl    = 6'd0;
  localparam logic [5:0] c_idx_status  = 6'd1;
  localparam logic [5:0] c_idx_lat_acc = 6'd2;
  localparam logic [5:0] c_idx_lat_add = 6'd3;
  localparam logic [5:0] c_idx_cs_max  = 6'd4;
  localparam logic [5:0] c_idx_rwr     = 6'd5;
  localparam logic [5:0] c_idx_dly     = 6'd6;
  localparam logic [5:0] c_idx_map0    = 6'd8;
  localparam logic [5:0] c_idx_map_end = 6'(8 + 2 * NR_CS);

  localparam logic [LAT_W-1:0]   c_rst_lat_acc = LAT_W'(RST_LAT_ACC);
  localparam logic [LAT_W-1:0]   c_rst_lat_add = LAT_W'(RST_LAT_ADD);
  localparam logic [LAT_W-1:0]   c_rst_rwr     = LAT_W'(RST_RWR);
  localparam logic [CSMAX_W-1:0] c_rst_csmax   = CSMAX_W'(RST_CSMAX);
  localparam logic [DLY_W-1:0]   c_rst_dly     = DLY_W'(RST_DLY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  function automatic logic [31:0] f_cs_start(input int unsigned i);
    return CS_SIZE * 32'(i);
  endfunction

  function automatic logic [31:0] f_cs_end(input int unsigned i);
    return CS_SIZE * 32'(i + 1) - 32'd1;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Shadow (software-visible) and active (controller-visible) register sets
  logic [LAT_W-1:0]   r_sh_lat_acc, r_sh_lat_add, r_sh_rwr;
  logic [CSMAX_W-1:0] r_sh_cs_max;
  logic [DLY_W-1:0]   r_sh_dly;
  logic [31:0]        r_sh_start [NR_CS];
  logic [31:0]        r_sh_end   [NR_CS];

  logic [LAT_W-1:0]   r_act_lat_acc, r_act_lat_add, r_act_rwr;
  logic [CSMAX_W-1:0] r_act_cs_max;
  logic [DLY_W-1:0]   r_act_dly;
  logic [31:0]        r_act_start [NR_CS];
  logic [31:0]        r_act_end   [NR_CS];

  state_t             r_state, w_state_nxt;
  logic               r_rvalid, r_error;
  logic [31:0]        r_rdata;

  logic [5:0]         w_idx, w_map_off;
  logic [c_cs_w-1:0]  w_map_sel;
  logic               w_map_is_end;
  logic               w_hit_field, w_hit_map, w_mapped, w_err;
  logic               w_wr_data, w_ctrl_wr, w_commit_req, w_clr_req;
  logic [31:0]        w_cur, w_wr_word;
  logic               w_apply, w_chk_fail, w_map_ok, w_commit_err;
  logic               w_unused;

  // ---------------------------------------------------------------- decode
  assign w_idx        = cfg.addr[7:2];
  assign w_map_off    = w_idx - c_idx_map0;
  assign w_map_sel    = w_map_off[c_cs_w:1];
  assign w_map_is_end = w_map_off[0];
  assign w_hit_field  = (w_idx >= c_idx_lat_acc) && (w_idx <= c_idx_dly);
  assign w_hit_map    = (w_idx >= c_idx_map0) && (w_idx < c_idx_map_end);
  assign w_mapped     = (w_idx == c_idx_ctrl) || (w_idx == c_idx_status) ||
                        w_hit_field || w_hit_map;
  assign w_err        = !w_mapped || (cfg.write && (w_idx == c_idx_status));
  assign w_wr_data    = cfg.valid && cfg.write && (w_hit_field || w_hit_map);
  assign w_ctrl_wr    = cfg.valid && cfg.write && (w_idx == c_idx_ctrl);
  assign w_commit_req = w_ctrl_wr && cfg.wstrb[0] && cfg.wdata[0];
  assign w_clr_req    = w_ctrl_wr && cfg.wstrb[0] && cfg.wdata[1];
  assign w_unused     = ^{cfg.addr[1:0], w_map_off};

  // Current shadow value, zero-extended; doubles as the read-modify base for writes
  always_comb begin
    w_cur = '0;
    case (w_idx)
      c_idx_status:  w_cur = {30'd0, w_commit_err, commit_pending_o};
      c_idx_lat_acc: w_cur = 32'(r_sh_lat_acc);
      c_idx_lat_add: w_cur = 32'(r_sh_lat_add);
      c_idx_cs_max:  w_cur = 32'(r_sh_cs_max);
      c_idx_rwr:     w_cur = 32'(r_sh_rwr);
      c_idx_dly:     w_cur = 32'(r_sh_dly);
      default:       w_cur = '0;
    endcase
    if (w_hit_map) begin
      w_cur = w_map_is_end ? r_sh_end[w_map_sel] : r_sh_start[w_map_sel];
    end
  end

  assign w_wr_word = f_merge(w_cur, cfg.wdata, cfg.wstrb);

  // ---------------------------------------------------------------- shadow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sh_lat_acc <= c_rst_lat_acc;
      r_sh_lat_add <= c_rst_lat_add;
      r_sh_cs_max  <= c_rst_csmax;
      r_sh_rwr     <= c_rst_rwr;
      r_sh_dly     <= c_rst_dly;
      for (int i = 0; i < NR_CS; i++) begin
        r_sh_start[i] <= f_cs_start(i);
        r_sh_end[i]   <= f_cs_end(i);
      end
    end else if (w_wr_data) begin
      case (w_idx)
        c_idx_lat_acc: r_sh_lat_acc <= w_wr_word[LAT_W-1:0];
        c_idx_lat_add: r_sh_lat_add <= w_wr_word[LAT_W-1:0];
        c_idx_cs_max:  r_sh_cs_max  <= w_wr_word[CSMAX_W-1:0];
        c_idx_rwr:     r_sh_rwr     <= w_wr_word[LAT_W-1:0];
        c_idx_dly:     r_sh_dly     <= w_wr_word[DLY_W-1:0];
        default: begin
          if (w_map_is_end) begin
            r_sh_end[w_map_sel] <= w_wr_word;
          end else begin
            r_sh_start[w_map_sel] <= w_wr_word;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- active
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_act_lat_acc <= c_rst_lat_acc;
      r_act_lat_add <= c_rst_lat_add;
      r_act_cs_max  <= c_rst_csmax;
      r_act_rwr     <= c_rst_rwr;
      r_act_dly     <= c_rst_dly;
      for (int i = 0; i < NR_CS; i++) begin
        r_act_start[i] <= f_cs_start(i);
        r_act_end[i]   <= f_cs_end(i);
      end
    end else if (w_apply) begin
      r_act_lat_acc <= r_sh_lat_acc;
      r_act_lat_add <= r_sh_lat_add;
      r_act_cs_max  <= r_sh_cs_max;
      r_act_rwr     <= r_sh_rwr;
      r_act_dly     <= r_sh_dly;
      for (int i = 0; i < NR_CS; i++) begin
        r_act_start[i] <= r_sh_start[i];
        r_act_end[i]   <= r_sh_end[i];
      end
    end
  end

  assign t_lat_acc_o = r_act_lat_acc;
  assign t_lat_add_o = r_act_lat_add;
  assign t_cs_max_o  = r_act_cs_max;
  assign t_rwr_o     = r_act_rwr;
  assign t_dly_o     = r_act_dly;

  for (genvar gi = 0; gi < NR_CS; gi++) begin : g_map
    assign addr_map_o[64*gi      +: 32] = r_act_start[gi];
    assign addr_map_o[64*gi + 32 +: 32] = r_act_end[gi];
  end

  // ---------------------------------------------------------------- map check
`ifdef HYPERBUS_CFG_MAP_CHECK_EN
  logic r_commit_err;

  always_comb begin
    w_map_ok = 1'b1;
    for (int i = 0; i < NR_CS; i++) begin
      if (r_sh_start[i] > r_sh_end[i]) begin
        w_map_ok = 1'b0;
      end
      for (int j = i + 1; j < NR_CS; j++) begin
        if (!((r_sh_end[i] < r_sh_start[j]) || (r_sh_end[j] < r_sh_start[i]))) begin
          w_map_ok = 1'b0;
        end
      end
    end
  end

  // A failing check on the same edge as CLR_ERR leaves the error set
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_commit_err <= 1'b0;
    end else if (w_chk_fail) begin
      r_commit_err <= 1'b1;
    end else if (w_clr_req) begin
      r_commit_err <= 1'b0;
    end
  end

  assign w_commit_err = r_commit_err;
`else
  logic w_unused_chk;

  assign w_map_ok     = 1'b1;
  assign w_commit_err = 1'b0;
  assign w_unused_chk = w_clr_req | w_chk_fail;
`endif

  // ---------------------------------------------------------------- commit FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    w_chk_fail  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_commit_req) begin
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (phy_idle_i) begin
          if (w_map_ok) begin
            w_apply     = 1'b1;
            w_state_nxt = S_APPLY;
          end else begin
            w_chk_fail  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_APPLY: begin
        w_state_nxt = w_commit_req ? S_PEND : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign commit_pending_o = (r_state == S_PEND);
  assign cfg_update_o     = (r_state == S_APPLY);

  // ---------------------------------------------------------------- response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_error  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= cfg.valid;
      r_error  <= cfg.valid && w_err;
      r_rdata  <= (cfg.valid && !cfg.write && !w_err) ? w_cur : '0;
    end
  end

  assign cfg.ready  = 1'b1;
  assign cfg.rvalid = r_rvalid;
  assign cfg.error  = r_error;
  assign cfg.rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_cfg_shadow_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hyperbus_cfg_shadow_regs
// Purpose  : Directed plus random stimulus against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyperbus_cfg_shadow_regs;

  localparam int          NR_CS   = 2;
  localparam logic [31:0] CS_SIZE = 32'h0040_0000;
  localparam int          MAPW    = 64 * NR_CS;

  logic            clk = 1'b0;
  logic            rst;
  logic            phy_idle;
  logic [3:0]      t_lat_acc, t_lat_add, t_rwr, t_dly;
  logic [15:0]     t_cs_max;
  logic [MAPW-1:0] addr_map;
  logic            cfg_update, commit_pending;

  hyperbus_cfg_shadow_regs_if bus ();

  hyperbus_cfg_shadow_regs #(.NR_CS(NR_CS), .CS_SIZE(CS_SIZE)) u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg              (bus),
    .phy_idle_i       (phy_idle),
    .t_lat_acc_o      (t_lat_acc),
    .t_lat_add_o      (t_lat_add),
    .t_rwr_o          (t_rwr),
    .t_cs_max_o       (t_cs_max),
    .t_dly_o          (t_dly),
    .addr_map_o       (addr_map),
    .cfg_update_o     (cfg_update),
    .commit_pending_o (commit_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: registers as a word array indexed by addr[7:2]
  logic [31:0] m_sh   [64];
  logic [31:0] m_act  [64];
  logic [31:0] m_mask [64];
  bit          m_pend, m_err, m_upd;
  logic        e_rvalid, e_error;
  logic [31:0] e_rdata;

  function automatic bit m_mapped(input int idx);
    return (idx <= 6) || (idx >= 8 && idx < 8 + 2 * NR_CS);
  endfunction

  function automatic bit m_map_ok();
    for (int i = 0; i < NR_CS; i++) begin
      if (m_sh[8+2*i] > m_sh[9+2*i]) return 0;
      for (int j = 0; j < NR_CS; j++)
        if (i != j && m_sh[8+2*i] <= m_sh[9+2*j] && m_sh[8+2*j] <= m_sh[9+2*i]) return 0;
    end
    return 1;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 64; k++) begin m_sh[k] = 0; m_mask[k] = 0; end
    m_sh[2] = 6;   m_mask[2] = 32'hF;
    m_sh[3] = 6;   m_mask[3] = 32'hF;
    m_sh[4] = 665; m_mask[4] = 32'hFFFF;
    m_sh[5] = 6;   m_mask[5] = 32'hF;
    m_sh[6] = 1;   m_mask[6] = 32'hF;
    for (int i = 0; i < NR_CS; i++) begin
      m_sh[8+2*i] = CS_SIZE * i;           m_mask[8+2*i] = 32'hFFFF_FFFF;
      m_sh[9+2*i] = CS_SIZE * (i + 1) - 1; m_mask[9+2*i] = 32'hFFFF_FFFF;
    end
    for (int k = 0; k < 64; k++) m_act[k] = m_sh[k];
    m_pend = 0; m_err = 0; m_upd = 0;
    e_rvalid = 0; e_error = 0; e_rdata = 0;
  endtask

  task automatic m_step(input logic v, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic idle);
    int idx = int'(a[7:2]);
    bit bad, commit, clr, ok, n_pend, n_upd, n_err;
    logic [31:0] bm;
    bad      = !m_mapped(idx) || (w && idx == 1);
    e_rvalid = v;
    e_error  = v && bad;
    e_rdata  = 0;
    if (v && !w && !bad)
      e_rdata = (idx == 0) ? 32'd0 : (idx == 1) ? {30'd0, m_err, m_pend} : m_sh[idx];
    commit = v && w && idx == 0 && s[0] && d[0];
    clr    = v && w && idx == 0 && s[0] && d[1];
`ifdef HYPERBUS_CFG_MAP_CHECK_EN
    ok = m_map_ok();
`else
    ok = 1;
`endif
    n_pend = m_pend; n_upd = 0; n_err = m_err;
    if (clr) n_err = 0;
    if (m_pend && idle) begin
      n_pend = 0;
      if (ok) begin
        for (int k = 0; k < 64; k++) m_act[k] = m_sh[k];
        n_upd = 1;
      end else n_err = 1;
    end
    if (commit && !m_pend) n_pend = 1;
    if (v && w && !bad && idx >= 2) begin
      bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      m_sh[idx] = ((m_sh[idx] & ~bm) | (d & bm)) & m_mask[idx];
    end
    m_pend = n_pend; m_upd = n_upd; m_err = n_err;
  endtask

  task automatic compare_all();
    logic [MAPW-1:0] em;
    for (int i = 0; i < NR_CS; i++) begin
      em[64*i +: 32]      = m_act[8+2*i];
      em[64*i + 32 +: 32] = m_act[9+2*i];
    end
    check("rvalid",    bus.rvalid,     e_rvalid);
    check("rdata",     bus.rdata,      e_rdata);
    check("error",     bus.error,      e_error);
    check("update",    cfg_update,     m_upd);
    check("pending",   commit_pending, m_pend);
    check("lat_acc",   t_lat_acc,      m_act[2]);
    check("lat_add",   t_lat_add,      m_act[3]);
    check("cs_max",    t_cs_max,       m_act[4]);
    check("rwr",       t_rwr,          m_act[5]);
    check("dly",       t_dly,          m_act[6]);
    check("addr_map",  addr_map,       em);
  endtask

  task automatic step(input logic v, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic idle);
    @(negedge clk);
    bus.valid = v; bus.write = w; bus.addr = a;
    bus.wdata = d; bus.wstrb = s; phy_idle = idle;
    m_step(v, w, a, d, s, idle);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0]  rd_addr [6] = '{8'h08, 8'h10, 8'h20, 8'h24, 8'h28, 8'h2C};
  logic [31:0] rd_exp  [6] = '{32'd6, 32'd665, 32'h0, 32'h3F_FFFF, 32'h40_0000, 32'h7F_FFFF};
  logic [7:0]  rnd_addr [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h40, 8'h00, 8'h24};

  initial begin
    logic [31:0] exp_status;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    bus.valid = 0; bus.write = 0; bus.addr = 0; bus.wdata = 0; bus.wstrb = 0;
    phy_idle = 1; rst = 1;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    #1;
    compare_all();
    check("ready", bus.ready, 1'b1);

    for (int k = 0; k < 6; k++) begin
      step(1, 0, rd_addr[k], 0, 0, 1);
      check("reset_read", bus.rdata, rd_exp[k]);
    end

    step(1, 1, 8'h08, 32'hFFFF_FFF3, 4'h1, 1);
    step(1, 0, 8'h08, 0, 0, 1);
    check("wstrb_field_read", bus.rdata, 32'h3);
    step(1, 1, 8'h40, 32'h1234_5678, 4'hF, 1);
    check("unmapped_write_err", bus.error, 1'b1);

    step(1, 1, 8'h08, 32'd9, 4'hF, 0);
    step(1, 1, 8'h00, 32'h1, 4'h1, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0);
    check("held_lat_acc", t_lat_acc, 4'd6);
    check("held_pending", commit_pending, 1'b1);
    step(0, 0, 0, 0, 0, 1);
    check("apply_lat_acc", t_lat_acc, 4'd9);
    check("apply_pulse", cfg_update, 1'b1);
    step(0, 0, 0, 0, 0, 1);

    step(1, 1, 8'h24, 32'h0050_0000, 4'hF, 1);
    step(1, 1, 8'h00, 32'h1, 4'h1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 8'h04, 0, 0, 1);
`ifdef HYPERBUS_CFG_MAP_CHECK_EN
    exp_status = 32'h2;
`else
    exp_status = 32'h0;
`endif
    check("overlap_status", bus.rdata, exp_status);
    step(1, 1, 8'h00, 32'h2, 4'h1, 1);
    step(1, 0, 8'h04, 0, 0, 1);
    check("clr_err_status", bus.rdata, 32'h0);

    for (int n = 0; n < 400; n++) begin
      a = rnd_addr[$urandom_range(0, 15)] | 8'($urandom_range(0, 3));
      if (a[7:2] == 6'd0) begin
        d = $urandom_range(0, 3);
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h1;
      end else begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, s,
           $urandom_range(0, 3) != 0);
    end

    step(1, 1, 8'h00, 32'h1, 4'h1, 0);
    step(0, 0, 0, 0, 0, 0);
    check("pend_before_reset", commit_pending, 1'b1);
    @(negedge clk);
    rst = 1;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    rst = 0;
    repeat (4) step(0, 0, 0, 0, 0, 1);
    check("no_pulse_after_reset", cfg_update, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
